// File: rtl/mcs51_int_ctrl_if.sv
// Core-side interrupt handshake between the mcs51 core and mcs51_int_ctrl.
// slave = controller view, master = core view.
interface mcs51_int_ctrl_if;
  logic        sample_en;
  logic        sfr_int_wr;
  logic        reti_pulse;
  logic        int_ack;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_prio;
  logic [2:0]  int_src;

  modport slave (
    input  sample_en, sfr_int_wr, reti_pulse, int_ack,
    output int_req, int_vector, int_prio, int_src
  );

  modport master (
    output sample_en, sfr_int_wr, reti_pulse, int_ack,
    input  int_req, int_vector, int_prio, int_src
  );
endinterface

// File: rtl/mcs51_int_ctrl.sv
// Sequential mcs51 interrupt scheduler: polls at instruction boundaries, holds a
// latched request until ack, tracks in-service levels. Nesting via MCS51_INT_NEST_EN.
//
// state | meaning
// IDLE  | no request; arbitrate on sample_en unless suppressed
// REQ   | latched request presented to the core, frozen until int_ack
// ACK   | one cycle: flag-clear strobe to the acknowledged source
module mcs51_int_ctrl #(
  parameter int          NUM_SRC  = 5,
  parameter logic [15:0] VEC_BASE = 16'h0003,
  parameter logic [15:0] VEC_STEP = 16'h0008
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_flag,
  input  logic [NUM_SRC-1:0] src_auto_clr,
  input  logic [NUM_SRC-1:0] ie_en,
  input  logic               ea,
  input  logic [NUM_SRC-1:0] ip,
  mcs51_int_ctrl_if.slave    core,
  output logic [NUM_SRC-1:0] clr_src,
  output logic [1:0]         in_service
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t       state, state_nxt;
  logic         suppress, suppress_nxt;
  logic [2:0]   src_q, src_nxt;
  logic [15:0]  vec_q, vec_nxt;
  logic         prio_q, prio_nxt;
  logic [1:0]   insvc_nxt;

  logic [NUM_SRC-1:0] cand, hi_cand, lo_cand, sel_mask;
  logic               win_prio, win_any, win_ok;
  logic [2:0]         win_idx;

  assign cand = {NUM_SRC{ea}} & ie_en & src_flag;

`ifdef MCS51_INT_NEST_EN
  assign hi_cand = cand & ip;
  assign lo_cand = cand & ~ip;
`else
  logic unused_ip;
  assign unused_ip = ^ip;
  assign hi_cand   = '0;
  assign lo_cand   = cand;
`endif

  // A blocked high candidate must not fall through to a low one.
  assign win_prio = |hi_cand;
  assign sel_mask = win_prio ? hi_cand : lo_cand;
  assign win_any  = |sel_mask;
  assign win_ok   = win_any && (win_prio ? !in_service[1] : (in_service == 2'b00));

  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (sel_mask[i]) win_idx = 3'(i);
  end

  always_comb begin
    state_nxt    = state;
    suppress_nxt = suppress;
    src_nxt      = src_q;
    vec_nxt      = vec_q;
    prio_nxt     = prio_q;
    insvc_nxt    = in_service;

    // RETI clears before an ack in the same cycle sets.
    if (core.reti_pulse) begin
      if (in_service[1])      insvc_nxt[1] = 1'b0;
      else if (in_service[0]) insvc_nxt[0] = 1'b0;
    end

    case (state)
      IDLE: begin
        if (core.sample_en) begin
          if (suppress) begin
            suppress_nxt = 1'b0;
          end else if (win_ok) begin
            src_nxt   = win_idx;
            vec_nxt   = VEC_BASE + 16'(win_idx) * VEC_STEP;
            prio_nxt  = win_prio;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (core.int_ack) begin
          insvc_nxt[prio_q] = 1'b1;
          state_nxt         = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (core.reti_pulse || core.sfr_int_wr) suppress_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      suppress   <= 1'b0;
      src_q      <= '0;
      vec_q      <= '0;
      prio_q     <= 1'b0;
      in_service <= 2'b00;
    end else begin
      state      <= state_nxt;
      suppress   <= suppress_nxt;
      src_q      <= src_nxt;
      vec_q      <= vec_nxt;
      prio_q     <= prio_nxt;
      in_service <= insvc_nxt;
    end
  end

  always_comb begin
    clr_src = '0;
    if (state == ACK) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (src_q == 3'(i)) clr_src[i] = src_auto_clr[i];
    end
  end

  assign core.int_req    = (state == REQ);
  assign core.int_vector = vec_q;
  assign core.int_prio   = prio_q;
  assign core.int_src    = src_q;

endmodule

// File: tb/tb_mcs51_int_ctrl.sv
// Directed self-checking bench for mcs51_int_ctrl; expectations follow
// MCS51_INT_NEST_EN where nesting changes the outcome.
module tb_mcs51_int_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] src_flag = '0;
  logic [4:0] src_auto_clr = '0;
  logic [4:0] ie_en = '0;
  logic       ea = 1'b0;
  logic [4:0] ip = '0;
  logic [4:0] clr_src;
  logic [1:0] in_service;

  int n_cmp = 0;
  int n_err = 0;

  mcs51_int_ctrl_if bus ();

  mcs51_int_ctrl #(.NUM_SRC(5), .VEC_BASE(16'h0003), .VEC_STEP(16'h0008)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_flag     (src_flag),
    .src_auto_clr (src_auto_clr),
    .ie_en        (ie_en),
    .ea           (ea),
    .ip           (ip),
    .core         (bus),
    .clr_src      (clr_src),
    .in_service   (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poll();
    bus.sample_en = 1'b1;
    tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic reti();
    bus.reti_pulse = 1'b1;
    tick();
    bus.reti_pulse = 1'b0;
  endtask

  task automatic sfr_wr();
    bus.sfr_int_wr = 1'b1;
    tick();
    bus.sfr_int_wr = 1'b0;
  endtask

  initial begin
    bus.sample_en  = 1'b0;
    bus.sfr_int_wr = 1'b0;
    bus.reti_pulse = 1'b0;
    bus.int_ack    = 1'b0;
    tick();
    tick();
    check("rst_req",   bus.int_req, 0);
    check("rst_vec",   bus.int_vector, 16'h0000);
    check("rst_prio",  bus.int_prio, 0);
    check("rst_src",   bus.int_src, 0);
    check("rst_clr",   clr_src, 5'b00000);
    check("rst_insvc", in_service, 2'b00);
    reset_n = 1'b1;
    tick();

    // basic poll: lowest-index pending source wins
    ea = 1'b1; ie_en = 5'h1F; src_auto_clr = 5'b01010; src_flag = 5'b00110;
    poll();
    check("p1_req",  bus.int_req, 1);
    check("p1_src",  bus.int_src, 1);
    check("p1_vec",  bus.int_vector, 16'h000B);
    check("p1_prio", bus.int_prio, 0);

    // frozen request
    src_flag = 5'b00000; ea = 1'b0;
    tick();
    ea = 1'b1; src_flag = 5'b00001;
    poll();
    check("frz_req", bus.int_req, 1);
    check("frz_vec", bus.int_vector, 16'h000B);
    check("frz_src", bus.int_src, 1);
    ack();
    check("ack1_req",   bus.int_req, 0);
    check("ack1_clr",   clr_src, 5'b00010);
    check("ack1_insvc", in_service, 2'b01);
    tick();
    check("ack1_clr_end", clr_src, 5'b00000);

    // ack while idle has no effect
    ack();
    check("idle_ack_insvc", in_service, 2'b01);
    check("idle_ack_req",   bus.int_req, 0);

    // RETI suppression
    src_flag = 5'b00000;
    reti();
    check("reti1_insvc", in_service, 2'b00);
    src_flag = 5'b00001;
    poll();
    check("sup_reti_req", bus.int_req, 0);
    poll();
    check("sup_reti_req2", bus.int_req, 1);
    check("sup_reti_vec",  bus.int_vector, 16'h0003);
    ack();
    check("ack0_clr",   clr_src, 5'b00000);
    check("ack0_insvc", in_service, 2'b01);
    tick();

    // SFR-write suppression
    reti();
    poll();
    check("sup_consume_req", bus.int_req, 0);
    sfr_wr();
    poll();
    check("sup_sfr_req", bus.int_req, 0);
    poll();
    check("sup_sfr_req2", bus.int_req, 1);
    check("sup_sfr_vec",  bus.int_vector, 16'h0003);
    ack();
    tick();

    // poll concurrent with sfr write uses old suppress value
    reti();
    poll();
    check("sup_consume2_req", bus.int_req, 0);
    bus.sfr_int_wr = 1'b1;
    poll();
    bus.sfr_int_wr = 1'b0;
    check("same_cyc_req", bus.int_req, 1);
    ack();
    tick();
    reti();
    poll();
    check("sup_consume3_req", bus.int_req, 0);

    // low source 3 with auto clear
    src_flag = 5'b01000;
    poll();
    check("s3_req", bus.int_req, 1);
    check("s3_vec", bus.int_vector, 16'h001B);
    ack();
    check("s3_clr",   clr_src, 5'b01000);
    check("s3_insvc", in_service, 2'b01);
    tick();
    check("s3_clr_end", clr_src, 5'b00000);

    ip = 5'b10000; src_flag = 5'b10000;
`ifdef MCS51_INT_NEST_EN
    poll();
    check("pre_req",  bus.int_req, 1);
    check("pre_vec",  bus.int_vector, 16'h0023);
    check("pre_prio", bus.int_prio, 1);
    check("pre_src",  bus.int_src, 4);
    ack();
    check("pre_clr",   clr_src, 5'b00000);
    check("pre_insvc", in_service, 2'b11);
    tick();
    reti();
    check("reti_hi_insvc", in_service, 2'b01);
    poll();
    check("pre2_sup_req", bus.int_req, 0);
    poll();
    check("pre2_req",  bus.int_req, 1);
    check("pre2_prio", bus.int_prio, 1);
    bus.reti_pulse = 1'b1;
    ack();
    bus.reti_pulse = 1'b0;
    check("reti_ack_insvc", in_service, 2'b10);
    tick();
    ip = 5'b00001; src_flag = 5'b00101;
    poll();
    poll();
    check("blk_req", bus.int_req, 0);
    reti();
    check("blk_reti_insvc", in_service, 2'b00);
`else
    poll();
    check("nonest_pre_req",  bus.int_req, 0);
    check("nonest_pre_prio", bus.int_prio, 0);
    reti();
    check("nonest_reti_insvc", in_service, 2'b00);
    poll();
    check("nonest_sup_req", bus.int_req, 0);
    poll();
    check("nonest_req",  bus.int_req, 1);
    check("nonest_src",  bus.int_src, 4);
    check("nonest_vec",  bus.int_vector, 16'h0023);
    check("nonest_prio", bus.int_prio, 0);
    ack();
    check("nonest_insvc", in_service, 2'b01);
    tick();
    ip = 5'b00001; src_flag = 5'b00101;
    poll();
    check("blk_req", bus.int_req, 0);
    reti();
    check("blk_reti_insvc", in_service, 2'b00);
`endif

    // reset while a request is latched
    src_flag = 5'b00000;
    poll();
    src_flag = 5'b00100;
    poll();
    check("r_req", bus.int_req, 1);
    check("r_vec", bus.int_vector, 16'h0013);
    #3;
    reset_n = 1'b0;
    #1;
    check("r_async_req", bus.int_req, 0);
    check("r_async_clr", clr_src, 5'b00000);
    tick();
    reset_n = 1'b1;
    tick();
    check("r_post_req", bus.int_req, 0);
    check("r_post_clr", clr_src, 5'b00000);
    poll();
    check("r_repoll_req", bus.int_req, 1);
    check("r_repoll_src", bus.int_src, 2);
    check("r_repoll_vec", bus.int_vector, 16'h0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
